// File: rtl/fixed_p_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module fixed_p_div_step #(
  parameter int width = 32
) (
  input  logic [width:0]   rem_in,
  input  logic             bit_in,
  input  logic [width-1:0] div,
  output logic [width:0]   rem_out,
  output logic             q_bit
);

  logic [width:0] shifted;
  logic [width:0] div_ext;
  logic [width:0] diff;
  logic           ge;

  // The remainder stays below the divisor between steps, so the shifted
  // value always fits in width+1 bits. A set top bit on rem_in could only
  // mean the shifted value is certainly >= divisor, so it forces the subtract.
  always_comb begin
    shifted = {rem_in[width-1:0], bit_in};
    div_ext = {1'b0, div};
    diff    = shifted - div_ext;
    ge      = rem_in[width] | (shifted >= div_ext);
    q_bit   = ge;
    rem_out = ge ? diff : shifted;
  end

endmodule

// File: rtl/fixed_p_std_seq_div.sv
// Sequential unsigned fixed-point divider. The dividend is pre-scaled by
// 2^fract_width and divided by restoring division, one quotient bit per
// BUSY cycle, MSB first. Results are registered and held until the next
// operation completes.
module fixed_p_std_seq_div #(
  parameter int width       = 32,
  parameter int int_width   = 8,
  parameter int fract_width = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             done
);

  // Number of iterations = bit width of the scaled dividend.
  localparam int N  = width + fract_width;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  generate
    if (int_width + fract_width != width) begin : g_bad_format
      $error("fixed_p_std_seq_div: int_width + fract_width must equal width");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     dvd_q, dvd_d;      // scaled dividend, shifted out MSB first
  logic [width-1:0] lft_q, lft_d;      // latched dividend (divide-by-zero result)
  logic [width-1:0] rgt_q, rgt_d;      // latched divisor
  logic [width:0]   rem_q, rem_d;      // partial remainder
  logic [width-1:0] quo_q, quo_d;      // quotient bits; only the low width are kept
  logic [width-1:0] oq_q, oq_d;
  logic [width-1:0] or_q, or_d;
  logic             done_q, done_d;

  logic [width:0]   step_rem;
  logic             step_q;
  logic [width-1:0] quo_next;

  fixed_p_div_step #(.width(width)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[N-1]),
    .div     (rgt_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Shifting into a width-bit register drops the high quotient bits, which
  // is exactly the wrap-around behaviour on overflow.
  assign quo_next = {quo_q[width-2:0], step_q};

  // Next-state, datapath and output-register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    lft_d   = lft_q;
    rgt_d   = rgt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    oq_d    = oq_q;
    or_d    = or_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = BUSY;
          lft_d   = left;
          rgt_d   = right;
          dvd_d   = {left, {fract_width{1'b0}}};
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = '0;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = quo_next;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (rgt_q == '0) begin
            oq_d = '1;
            or_d = lft_q;
          end else begin
            oq_d = quo_next;
            or_d = step_rem[width-1:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      lft_q   <= '0;
      rgt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      oq_q    <= '0;
      or_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      lft_q   <= lft_d;
      rgt_q   <= rgt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      done_q  <= done_d;
    end
  end

  assign out_quotient  = oq_q;
  assign out_remainder = or_q;
  assign done          = done_q;

endmodule

// File: tb/tb_fixed_p_std_seq_div.sv
// Scoreboard bench for fixed_p_std_seq_div at width=8, 4.4 format.
module tb_fixed_p_std_seq_div;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int FW = 4;
  localparam int N  = W + FW;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         done;

  fixed_p_std_seq_div #(.width(W), .int_width(IW), .fract_width(FW)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    time          t0;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;
  logic         prev_done = 1'b0;
  logic         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: D = left * 2^FW as an N-bit value, floor-divide, keep low W bits.
  function automatic exp_t model(input logic [W-1:0] l, input logic [W-1:0] r, input time t0);
    exp_t         e;
    logic [N-1:0] d;
    d    = {l, {FW{1'b0}}};
    e.t0 = t0;
    if (r == '0) begin
      e.q = '1;
      e.r = l;
    end else begin
      e.q = W'(d / N'(r));
      e.r = W'(d % N'(r));
    end
    return e;
  endfunction

  // Output monitor: check each done pulse against the scoreboard, and that
  // outputs hold their last result at all other times.
  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (done) begin
        chk("done_pulse_width", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("quotient", 32'(out_quotient), 32'(mon_e.q));
          chk("remainder", 32'(out_remainder), 32'(mon_e.r));
          chk("latency", 32'(($time - 5 - mon_e.t0) / 10), 32'(N));
          hold_q = mon_e.q;
          hold_r = mon_e.r;
        end
      end else begin
        chk("hold_quotient", 32'(out_quotient), 32'(hold_q));
        chk("hold_remainder", 32'(out_remainder), 32'(hold_r));
      end
      prev_done = done;
    end
  end

  // Launch one operation with a one-cycle go; operands are scrambled after
  // the start edge to show they are not re-sampled.
  task automatic start(input logic [W-1:0] l, input logic [W-1:0] r);
    @(posedge clk);
    #1 left = l; right = r; go = 1'b1;
    @(posedge clk);
    sb.push_back(model(l, r, $time));
    #1 go = 1'b0;
    left  = W'($urandom);
    right = W'($urandom);
  endtask

  // Wait (bounded) for all outstanding results, then for the return to IDLE.
  task automatic wait_idle();
    for (int i = 0; i < 4 * N && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("timeout_waiting_done", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("reset_quotient", 32'(out_quotient), 32'd0);
    chk("reset_remainder", 32'(out_remainder), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Directed cases, including divide-by-zero and overflow wrap.
    start(8'h30, 8'h20); wait_idle();
    start(8'h10, 8'h30); wait_idle();
    start(8'h30, 8'h00); wait_idle();
    start(8'hF0, 8'h01); wait_idle();
    start(8'hFF, 8'hFF); wait_idle();
    start(8'h00, 8'h05); wait_idle();

    // go pulsed mid-operation must be ignored.
    start(8'h7B, 8'h0D);
    repeat (4) @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    wait_idle();

    // Random operands, occasional zero divisor.
    for (int k = 0; k < 8; k++) begin
      start(W'($urandom), (k == 5) ? 8'h00 : W'($urandom_range(1, 255)));
      wait_idle();
    end

    // go held high: restarts every N+2 cycles with the operands present at
    // each start edge.
    @(posedge clk);
    #1 left = 8'h30; right = 8'h20; go = 1'b1;
    @(posedge clk);
    sb.push_back(model(8'h30, 8'h20, $time));
    #1 left = 8'h10; right = 8'h30;
    repeat (N + 2) @(posedge clk);
    sb.push_back(model(8'h10, 8'h30, $time));
    #1 left = 8'h55; right = 8'h07;
    repeat (N + 2) @(posedge clk);
    sb.push_back(model(8'h55, 8'h07, $time));
    #1 go = 1'b0; left = 8'hAA; right = 8'h11;
    wait_idle();

    // Reset at BUSY cycle 5 aborts the operation and clears outputs at once.
    start(8'h3C, 8'h05);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    sb.delete();
    hold_q = '0;
    hold_r = '0;
    #1;
    chk("abort_quotient", 32'(out_quotient), 32'd0);
    chk("abort_remainder", 32'(out_remainder), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    // First edge after release must accept go.
    reset = 1'b1;
    left  = 8'h48;
    right = 8'h30;
    go    = 1'b1;
    @(posedge clk);
    sb.push_back(model(8'h48, 8'h30, $time));
    #1 go = 1'b0;
    wait_idle();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_p_std_seq_div.md
FIXED_P_STD_SEQ_DIV -- requirements
Module: fixed_p_std_seq_div

Interface
REQ-001 Parameter width, default 32: total operand/result bit width.
REQ-002 Parameter int_width, default 8: integer bits of every operand and result.
REQ-003 Parameter fract_width, default 24: fractional bits of every operand and result.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  reset; asynchronous, active-low (asserted when 0).
REQ-006 go  input  1  start request; sampled only in IDLE.
REQ-007 left  input  width  unsigned fixed-point dividend.
REQ-008 right  input  width  unsigned fixed-point divisor.
REQ-009 out_quotient  output  width  registered fixed-point quotient.
REQ-010 out_remainder  output  width  registered remainder, in raw integer units of the scaled dividend.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 Compile-time error if int_width + fract_width != width.
REQ-013 Let N = width + fract_width, and D = left * 2^fract_width as an N-bit value.
REQ-014 Result: out_quotient = floor(D / right) mod 2^width; out_remainder = D mod right.
REQ-015 Overflow (true quotient >= 2^width): low width bits delivered; no saturation, no flag.
REQ-016 right == 0: out_quotient = all ones, out_remainder = latched left; latency unchanged.
REQ-017 Algorithm: unsigned restoring division, one quotient bit per BUSY cycle, MSB first.
REQ-018 Partial remainder register: width+1 bits; no combinational divider or multiplier.
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE -> BUSY on an edge with go=1; left/right latched; iteration counter cleared.
REQ-021 BUSY: one iteration per edge; after iteration N, go to DONE and load outputs at that edge.
REQ-022 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-023 done rises exactly N cycles after the edge that sampled go.
REQ-024 go in BUSY or DONE is ignored; operand changes after the start edge are ignored.
REQ-025 go held high continuously: next operation starts at the first edge in IDLE, so the sustained period is N+2 cycles.
REQ-026 out_quotient/out_remainder hold their values until the next DONE entry.
REQ-027 out_quotient/out_remainder are never updated mid-operation.

Reset
REQ-028 reset=0 forces IDLE immediately, independent of clk.
REQ-029 Reset values: out_quotient=0, out_remainder=0, done=0, counter=0, operand and partial registers=0.
REQ-030 Reset in BUSY or DONE aborts the operation; no done pulse for it; outputs read 0.
REQ-031 First go is accepted on the first rising edge after reset deassertion.

Structure
REQ-032 No shared package; state enum and N localparam are local to the module.
REQ-033 One sub-module, fixed_p_div_step: combinational single restoring step.
REQ-034 fixed_p_div_step: partial remainder and divisor in -> next partial remainder and quotient bit out.

Verification (width=8, int_width=4, fract_width=4, N=12)
REQ-035 left=0x30 (3.0), right=0x20 (2.0), go 1 cycle -> done 12 cycles later; quotient=0x18 (1.5), remainder=0x00.
REQ-036 left=0x10, right=0x30 -> quotient=0x05, remainder=0x10.
REQ-037 left=0x30, right=0x00 -> quotient=0xFF, remainder=0x30, done at cycle 12.
REQ-038 left=0xF0, right=0x01 (overflow) -> quotient=0x00, remainder=0x00.
REQ-039 Back-to-back starts: go held high with operands changed during BUSY -> each result uses its start-edge operands; done pulses are 14 cycles apart.
REQ-040 reset=0 asserted at BUSY cycle 5 -> outputs 0 immediately, no done; a new go after release gives a correct result.
